// File: rtl/pcie2axil_read_engine.sv
`default_nettype none
// ============================================================================
// Module   : pcie2axil_read_engine
// Brief    : PCIe memory-read to AXI4-Lite read bridge. Translates BAR hits
//            to AXI addresses, keeps up to MAX_OUTSTANDING reads in flight
//            and returns each R beat in order with its tag, byte enables
//            and an error flag.
// Options  : PCIE2AXIL_RRESP_ERR_FILL_EN - force completion data to
//            all-ones when rresp is non-zero.
// Revision : 1.0 - initial pipelined release
// ============================================================================
module pcie2axil_read_engine #(
    parameter int                        TCQ             = 1,
    parameter int                        AXI_DATA_WIDTH  = 64,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        MAX_OUTSTANDING = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR0AXI         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR1AXI         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR2AXI         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR3AXI         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR4AXI         = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BAR5AXI         = '0,
    parameter int                        BAR0SIZE        = 12,
    parameter int                        BAR1SIZE        = 12,
    parameter int                        BAR2SIZE        = 12,
    parameter int                        BAR3SIZE        = 12,
    parameter int                        BAR4SIZE        = 12,
    parameter int                        BAR5SIZE        = 12
) (
    input  logic                                 m_axi_aclk,
    input  logic                                 m_axi_aresetn,
    input  logic                                 mem_req_valid,
    output logic                                 mem_req_ready,
    input  logic [2:0]                           mem_req_bar_hit,
    input  logic [31:0]                          mem_req_pcie_address,
    input  logic [3:0]                           mem_req_byte_enable,
    input  logic [7:0]                           mem_req_tag,
    input  logic                                 mem_req_write_readn,
    output logic [AXI_ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [2:0]                           m_axi_arprot,
    output logic                                 m_axi_arvalid,
    input  logic                                 m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                           m_axi_rresp,
    input  logic                                 m_axi_rvalid,
    output logic                                 m_axi_rready,
    output logic                                 axi_cpld_valid,
    input  logic                                 axi_cpld_ready,
    output logic [AXI_DATA_WIDTH-1:0]            axi_cpld_data,
    output logic [7:0]                           axi_cpld_tag,
    output logic [3:0]                           axi_cpld_byte_enable,
    output logic                                 axi_cpld_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding
);

    localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_META_W = 12;

    // TCQ is kept so existing instantiations still elaborate; registers here
    // carry no modelled clock-to-Q delay.
    if (TCQ < 0) begin : g_tcq_range
    end

    logic [AXI_ADDR_WIDTH-1:0] w_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_xlate_addr;
    logic                      w_accept;
    logic                      w_r_hs;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic [c_META_W-1:0]       w_head;

    logic                      r_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [c_CNT_W-1:0]        r_count;
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_META_W-1:0]       r_meta [MAX_OUTSTANDING];

    // Fit the 32-bit PCIe address to the AXI address width.
    if (AXI_ADDR_WIDTH > 32) begin : g_addr_zext
        assign w_pcie_addr = {{(AXI_ADDR_WIDTH-32){1'b0}}, mem_req_pcie_address};
    end else if (AXI_ADDR_WIDTH == 32) begin : g_addr_same
        assign w_pcie_addr = mem_req_pcie_address;
    end else begin : g_addr_trunc
        logic w_unused_addr_hi;
        assign w_pcie_addr      = mem_req_pcie_address[AXI_ADDR_WIDTH-1:0];
        assign w_unused_addr_hi = ^mem_req_pcie_address[31:AXI_ADDR_WIDTH];
    end

    // Window base above SIZE, DW-aligned offset below it.
    function automatic logic [AXI_ADDR_WIDTH-1:0] f_xlate(
        input logic [AXI_ADDR_WIDTH-1:0] base,
        input int                        size,
        input logic [AXI_ADDR_WIDTH-1:0] pa
    );
        logic [AXI_ADDR_WIDTH-1:0] mask;
        logic [AXI_ADDR_WIDTH-1:0] dw_mask;
        mask    = {AXI_ADDR_WIDTH{1'b1}} << size;
        dw_mask = {{(AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};
        return (base & mask) | (pa & ~mask & dw_mask);
    endfunction

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // BAR window lookup; hits 6 and 7 map to address 0 but still issue.
    always_comb begin
        w_xlate_addr = '0;
        case (mem_req_bar_hit)
            3'd0:    w_xlate_addr = f_xlate(BAR0AXI, BAR0SIZE, w_pcie_addr);
            3'd1:    w_xlate_addr = f_xlate(BAR1AXI, BAR1SIZE, w_pcie_addr);
            3'd2:    w_xlate_addr = f_xlate(BAR2AXI, BAR2SIZE, w_pcie_addr);
            3'd3:    w_xlate_addr = f_xlate(BAR3AXI, BAR3SIZE, w_pcie_addr);
            3'd4:    w_xlate_addr = f_xlate(BAR4AXI, BAR4SIZE, w_pcie_addr);
            3'd5:    w_xlate_addr = f_xlate(BAR5AXI, BAR5SIZE, w_pcie_addr);
            default: w_xlate_addr = '0;
        endcase
    end

    assign mem_req_ready = m_axi_aresetn & (~r_arvalid | m_axi_arready) &
                           (r_count < c_CNT_W'(MAX_OUTSTANDING));
    assign w_accept      = mem_req_valid & mem_req_ready & ~mem_req_write_readn;
    assign w_r_hs        = m_axi_rvalid & axi_cpld_ready & m_axi_aresetn;
    assign w_fifo_empty  = (r_count == '0);
    // A beat with nothing outstanding is an orphan and must not pop.
    assign w_pop         = w_r_hs & ~w_fifo_empty;

    // AR output register: holds until arready, reloads back-to-back.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else if (w_accept) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_xlate_addr;
        end else if (m_axi_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    // Metadata storage; validity is tracked by the occupancy counter.
    always_ff @(posedge m_axi_aclk) begin
        if (w_accept) begin
            r_meta[r_wr_ptr] <= {mem_req_tag, mem_req_byte_enable};
        end
    end

    // FIFO pointers and in-flight counter.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head               = r_meta[r_rd_ptr];
    assign axi_cpld_tag         = w_fifo_empty ? 8'h00 : w_head[11:4];
    assign axi_cpld_byte_enable = w_fifo_empty ? 4'h0  : w_head[3:0];
    assign axi_cpld_err         = (m_axi_rresp != 2'b00) | w_fifo_empty;
    assign axi_cpld_valid       = m_axi_rvalid & m_axi_aresetn;
    assign m_axi_rready         = axi_cpld_ready & m_axi_aresetn;

`ifdef PCIE2AXIL_RRESP_ERR_FILL_EN
    assign axi_cpld_data = (m_axi_rresp != 2'b00) ? {AXI_DATA_WIDTH{1'b1}} : m_axi_rdata;
`else
    assign axi_cpld_data = m_axi_rdata;
`endif

    assign m_axi_araddr   = r_araddr;
    assign m_axi_arvalid  = r_arvalid;
    assign m_axi_arprot   = 3'b000;
    assign rd_outstanding = r_count;

endmodule
`default_nettype wire
